// File: rtl/sine_phase_sequencer_if.sv
// Table/sample bundle for sine_phase_sequencer: the table address/data/size lines
// and the registered sample stream handed to the PWM/DAC consumer.
interface sine_phase_sequencer_if #(
  parameter int SINE_SIZE      = 8,
  parameter int TABLE_REG_SIZE = 6
);
  logic [TABLE_REG_SIZE-1:0] table_addr;
  logic [TABLE_REG_SIZE-1:0] table_size;
  logic [SINE_SIZE-1:0]      table_data;
  logic [SINE_SIZE-1:0]      sample;
  logic                      sample_valid;
  logic                      falling;
  logic                      period_done;

  modport master (
    output table_addr, sample, sample_valid, falling, period_done,
    input  table_size, table_data
  );

  modport slave (
    input  table_addr, sample, sample_valid, falling, period_done,
    output table_size, table_data
  );
endinterface

// File: rtl/sine_phase_sequencer.sv
// Walks a half-sine table up then down to produce a full-period sample stream.
// Optional macro SINE_SKIP_ENDPOINT_EN: turnarounds do not repeat the endpoint address.
module sine_phase_sequencer #(
  parameter int SINE_SIZE      = 8,
  parameter int TABLE_REG_SIZE = 6,
  parameter int DIV_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   restart,
  input  logic [DIV_WIDTH-1:0]   div,
  sine_phase_sequencer_if.master bus
);
  typedef enum logic {
    ST_RISE = 1'b0,
    ST_FALL = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [DIV_WIDTH-1:0]      cnt_q, cnt_d;
  logic [TABLE_REG_SIZE-1:0] addr_q, addr_d;
  logic [SINE_SIZE-1:0]      sample_q, sample_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic [TABLE_REG_SIZE-1:0] rise_turn_s;
  logic [TABLE_REG_SIZE-1:0] fall_turn_s;

`ifdef SINE_SKIP_ENDPOINT_EN
  assign rise_turn_s = bus.table_size - TABLE_REG_SIZE'(1);
  assign fall_turn_s = TABLE_REG_SIZE'(1);
`else
  assign rise_turn_s = bus.table_size;
  assign fall_turn_s = {TABLE_REG_SIZE{1'b0}};
`endif

  // Next-state: prescaler, sample capture and up/down address walk
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    if (restart) begin
      state_d  = ST_RISE;
      cnt_d    = {DIV_WIDTH{1'b0}};
      addr_d   = {TABLE_REG_SIZE{1'b0}};
      sample_d = {SINE_SIZE{1'b0}};
    end else if (en) begin
      // >= keeps a lowered div from overrunning the current count
      if (cnt_q >= div) begin
        cnt_d    = {DIV_WIDTH{1'b0}};
        sample_d = bus.table_data;
        valid_d  = 1'b1;
        case (state_q)
          ST_RISE: begin
            if (addr_q >= bus.table_size) begin
              state_d = ST_FALL;
              addr_d  = rise_turn_s;
            end else begin
              addr_d = addr_q + TABLE_REG_SIZE'(1);
            end
          end
          ST_FALL: begin
            if (addr_q == {TABLE_REG_SIZE{1'b0}}) begin
              state_d = ST_RISE;
              done_d  = 1'b1;
              addr_d  = fall_turn_s;
            end else if (addr_q > bus.table_size) begin
              addr_d = bus.table_size;
            end else begin
              addr_d = addr_q - TABLE_REG_SIZE'(1);
            end
          end
          default: begin
            state_d = ST_RISE;
            addr_d  = {TABLE_REG_SIZE{1'b0}};
          end
        endcase
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RISE;
      cnt_q    <= {DIV_WIDTH{1'b0}};
      addr_q   <= {TABLE_REG_SIZE{1'b0}};
      sample_q <= {SINE_SIZE{1'b0}};
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign bus.table_addr   = addr_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.period_done  = done_q;
  assign bus.falling      = (state_q == ST_FALL);
endmodule

// File: doc/sine_phase_sequencer.md
# sine_phase_sequencer

Drives the address input of the half-sine lookup table and registers its combinational data output into a full-period sine sample stream. Walks the table address up (rising half) then down (falling half) at a programmable sample rate. Emits one registered sample per step with a valid strobe and a once-per-period marker. Sits between the half-sine table and the downstream PWM/DAC consumer.

## Interface
- `SINE_SIZE`, 8, sample width; matches the table data width.
- `TABLE_REG_SIZE`, 6, table address width.
- `DIV_WIDTH`, 16, width of the sample-rate divider.

- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `en`  in  1  run enable; low pauses the sequencer with all state held.
- `restart`  in  1  synchronous restart to the start of a period; has priority over `en`.
- `div`  in  DIV_WIDTH  clock cycles per sample minus 1.
- `table_size`  in  TABLE_REG_SIZE  maximum valid table address, from the table; must be ≥2.
- `table_data`  in  SINE_SIZE  table output for `table_addr`, combinational.
- `table_addr`  out  TABLE_REG_SIZE  registered address to the table.
- `sample`  out  SINE_SIZE  registered sine sample.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `falling`  out  1  0 = rising half (address incrementing), 1 = falling half.
- `period_done`  out  1  one-cycle pulse, coincident with `sample_valid`, on the last sample of a period.

## Operation
- States: RISE (`falling`=0) and FALL (`falling`=1). Reset and `restart` select RISE.
- Prescaler `cnt` (DIV_WIDTH bits):
  - While `en`=1: if `cnt` ≥ `div`, a step occurs and `cnt` goes to 0; otherwise `cnt` increments.
  - Because the compare is ≥, lowering `div` mid-count never overruns.
  - `div`=0 gives a step every cycle.
- On every step:
  - `sample` ← `table_data`, which is the value at the current `table_addr`.
  - `sample_valid` = 1 for that cycle.
  - The address then advances as follows.
- RISE:
  - If `addr` ≠ `table_size`: `addr`+1.
  - Else: go to FALL; `addr` ← `table_size` (endpoint repeated; see Configuration).
- FALL:
  - If `addr` ≠ 0: `addr`−1.
  - Else: go to RISE, `period_done` pulses, and `addr` ← 0.
- With `en`=0: no steps, `cnt` held, all outputs held, strobes 0. Re-asserting `en` resumes exactly where the sequencer stopped.
- `restart`=1:
  - `cnt`=0, `table_addr`=0, RISE, `sample`=0, strobes 0.
  - The next step occurs `div`+1 cycles after `restart` falls, provided `en`=1.
- Default period is 2·(`table_size`+1) samples. For `table_size`=55 that is 112 samples: 0,1…55,55,54…0.
- Address arithmetic never wraps; `table_addr` stays in 0…`table_size`.

## Timing
- All outputs are registered. Reset values:
  - `table_addr`=0, `sample`=0, `sample_valid`=0, `period_done`=0, `falling`=0.
  - Internal `cnt`=0.
- Table access is combinational, so a sample is captured in the same edge that advances the address. `sample` reflects the address presented before that edge.
- First `sample_valid` comes `div`+1 cycles after `en` rises following reset; `sample` = table[0].
- `sample_valid` and `period_done` last exactly one cycle. `period_done` occurs only together with `sample_valid`.
- Asynchronous reset mid-period: immediate return to the reset values. No partial strobe after release.
- `restart` and `en` in the same cycle: `restart` wins.

## Configuration
- `SINE_SKIP_ENDPOINT_EN` defined: turnarounds do not repeat endpoints.
  - RISE at `table_size` moves to `table_size`−1.
  - FALL at 0 moves to 1.
  - Sequence 0,1…55,54…1,0,1…
  - First period after reset/restart is 2·`table_size`+1 samples (111); later periods are 2·`table_size` samples (110).
- Undefined: endpoints are repeated as described in Operation; every period is 2·(`table_size`+1) samples.

## Test plan
- Reset, `en`=1, `div`=0, `table_size`=55 (macro off) → `sample_valid` every cycle; samples 0,0,1,2…255,255,254…0; `period_done` on sample 112; pattern repeats identically.
- `div`=3 → `sample_valid` exactly every 4 cycles; first pulse 4 cycles after `en` rises.
- Macro on, `div`=0 → first `period_done` at sample 111, then every 110 samples; the peak value 255 appears once per period.
- Drop `en` for 10 cycles mid-rise at `addr`=20 → no strobes, `table_addr`=20 held; resumes with next sample table[20].
- Pulse `restart` at `addr`=40 in FALL → next cycle `table_addr`=0, `falling`=0, `sample`=0; sequence restarts from 0.
- Change `div` from 100 to 2 while `cnt`=50 → step on the next cycle, then every 3 cycles.
